mem_responder: RTL and testbench

Memory-side responder for the CPU's external bus: holds `A`, `Dout` (write data) and `Din` (read data) from the core's fetch/load/store path and serves them from an internal word-organised RAM. A request/ready handshake carries each access, with a parameterised number of wait states. Byte-enable writes are supported, and misaligned or out-of-range accesses are reported as errors. It is the target end of the interface the core initiates; fetch and data accesses are indistinguishable to it.

---
 rtl/mem_responder.sv | 68 ++++++
 tb/tb_mem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM target for the core's external bus,
// with a req/ready handshake, wait states, byte enables and fault reporting.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] din,
    input  logic [3:0]  be,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic fault, we_q, accept, fire, bad;
    logic [AW-1:0] idx;
    logic [31:0] wdata;
    logic [3:0] be_q;
    logic [31:0] ram [DEPTH_WORDS];
    assign accept = state == IDLE && req;
    assign fire = state == ACCESS && cnt == 4'd0;
    // Range check uses the full word index so high address bits never alias.
    assign bad = A[1:0] != 2'b00 || {2'b00, A[31:2]} >= 32'(DEPTH_WORDS);
    always_comb begin
        state_nx = state;
        state_nx = accept ? ACCESS : fire ? RESP : state == RESP ? IDLE : state;
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 4'd0;
            fault <= 1'b0;
            dout <= 32'd0;
        end else begin
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
                fault <= bad;
                we_q <= we;
                idx <= A[AW+1:2];
                wdata <= din;
                be_q <= be;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !we_q) dout <= fault ? 32'd0 : ram[idx];
        end
    end
    // Reset wins over a coinciding completion edge, so the write is dropped.
    always_ff @(posedge clock) begin
        if (!reset && fire && we_q && !fault)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign ready = state == RESP;
    assign err = state == RESP && fault;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of three responders with WAIT_CYCLES 1, 3 and 0.
module tb_mem_responder;
    logic clk;
    logic rst [3];
    logic req [3];
    logic we [3];
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic [3:0] be [3];
    logic [31:0] q [3];
    logic rdy [3];
    logic er [3];
    logic bsy [3];
    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 0)) dut (
            .clock(clk), .reset(rst[g]), .req(req[g]), .we(we[g]), .A(a[g]), .din(d[g]),
            .be(be[g]), .dout(q[g]), .ready(rdy[g]), .err(er[g]), .busy(bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wk(input int k);
        return k == 0 ? 1 : k == 1 ? 3 : 0;
    endfunction

    task automatic xfer(input int k, input logic w, input logic [31:0] addr, input logic [31:0] dat,
                        input logic [3:0] m, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; a[k] = addr; d[k] = dat; be[k] = m;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (rdy[k]) begin
                lat = n;
                break;
            end
        end
        rd = q[k];
        e = er[k];
        @(negedge clk);
        req[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int k, input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] m,
                      input logic exp_err, input string tag);
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(k, 1'b1, addr, dat, m, rd, e, lat);
        chk({tag, "_lat"}, lat, wk(k) + 1);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rdc(input int k, input logic [31:0] addr, input logic [31:0] exp,
                       input logic exp_err, input string tag);
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(k, 1'b0, addr, 32'd0, 4'hf, rd, e, lat);
        chk({tag, "_lat"}, lat, wk(k) + 1);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        chk({tag, "_dout"}, rd, exp);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b1; we[k] = 1'b0; a[k] = 32'd0; d[k] = 32'd0; be[k] = 4'hf;
        end
        // Reset held two cycles with req asserted: everything stays quiet.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
                chk("rst_err", {31'd0, er[k]}, 32'd0);
                chk("rst_busy", {31'd0, bsy[k]}, 32'd0);
                chk("rst_dout", q[k], 32'd0);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("first_accept_busy", {31'd0, bsy[k]}, 32'd1);
            req[k] = 1'b0;
        end
        repeat (6) @(posedge clk);

        // W=1 write/read, byte enables, faults
        wr(0, 32'h10, 32'hDEADBEEF, 4'hf, 1'b0, "w_full");
        rdc(0, 32'h10, 32'hDEADBEEF, 1'b0, "r_full");
        wr(0, 32'h10, 32'h11223344, 4'hf, 1'b0, "w_base");
        wr(0, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, "w_be");
        rdc(0, 32'h10, 32'h11BB33DD, 1'b0, "r_be");
        wr(0, 32'h10, 32'h99999999, 4'b0000, 1'b0, "w_be0");
        rdc(0, 32'h10, 32'h11BB33DD, 1'b0, "r_be0");
        wr(0, 32'h0, 32'hCAFEF00D, 4'hf, 1'b0, "w_word0");
        rdc(0, 32'h2, 32'h0, 1'b1, "r_misalign");
        wr(0, 32'h1000, 32'hFFFFFFFF, 4'hf, 1'b1, "w_oor");
        chk("dout_hold_fault_wr", q[0], 32'h0);
        wr(0, 32'h0010_0000, 32'hFFFFFFFF, 4'hf, 1'b1, "w_oor_alias");
        wr(0, 32'h3, 32'hFFFFFFFF, 4'hf, 1'b1, "w_misalign");
        rdc(0, 32'h0, 32'hCAFEF00D, 1'b0, "r_word0");
        wr(0, 32'hFFC, 32'h5A5A0001, 4'hf, 1'b0, "w_last");
        chk("dout_hold_wr", q[0], 32'hCAFEF00D);
        rdc(0, 32'hFFC, 32'h5A5A0001, 1'b0, "r_last");

        // W=3: reset on the completion edge aborts the write
        wr(1, 32'h20, 32'h0BADCAFE, 4'hf, 1'b0, "w3_prior");
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h20; d[1] = 32'h12345678; be[1] = 4'hf;
        @(posedge clk); #1;
        chk("w3_accept_busy", {31'd0, bsy[1]}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("w3_wait_ready", {31'd0, rdy[1]}, 32'd0);
        end
        @(negedge clk);
        rst[1] = 1'b1; req[1] = 1'b0;
        @(posedge clk); #1;
        chk("w3_abort_ready", {31'd0, rdy[1]}, 32'd0);
        chk("w3_abort_busy", {31'd0, bsy[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("w3_no_ready", {31'd0, rdy[1]}, 32'd0);
        end
        rdc(1, 32'h20, 32'h0BADCAFE, 1'b0, "r3_prior");

        // W=0: three back-to-back reads with req held high
        wr(2, 32'h100, 32'h00000A0A, 4'hf, 1'b0, "w0_a");
        wr(2, 32'h104, 32'h00000B0B, 4'hf, 1'b0, "w0_b");
        wr(2, 32'h108, 32'h00000C0C, 4'hf, 1'b0, "w0_c");
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; a[2] = 32'h100;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk($sformatf("tp_ready%0d", n), {31'd0, rdy[2]}, {31'd0, n % 3 == 1 && n <= 7});
            chk($sformatf("tp_busy%0d", n), {31'd0, bsy[2]}, {31'd0, n % 3 != 2 && n <= 7});
            if (n == 1) chk("tp_dout0", q[2], 32'h00000A0A);
            if (n == 4) chk("tp_dout1", q[2], 32'h00000B0B);
            if (n == 7) chk("tp_dout2", q[2], 32'h00000C0C);
            if (n == 0) a[2] = 32'h104;
            if (n == 3) a[2] = 32'h108;
            if (n == 6) req[2] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
